dmem_sramlike_bridge: RTL and testbench



---
 rtl/dmem_sramlike_bridge_pkg.sv | 8 +
 rtl/dmem_sramlike_bridge_if.sv | 40 ++++
 rtl/dmem_sramlike_bridge.sv | 103 ++++++++++
 tb/tb_dmem_sramlike_bridge.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dmem_sramlike_bridge_pkg.sv
// Shared definitions for the data-side sram-like bridge: FSM states and bus size codes.
package cpu_defs;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD, DRAIN} dbridge_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/dmem_sramlike_bridge_if.sv
// M-stage request/response signals and the sram-like data bus, bundled for the bridge.
interface dmem_sramlike_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_wr;
  logic [1:0]        cpu_size;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_cancel;
  logic              cpu_busy;
  logic [DATA_W-1:0] cpu_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // bridge side
  modport slave (
    input  cpu_req, cpu_wr, cpu_size, cpu_addr, cpu_wdata, cpu_stall, cpu_cancel,
    output cpu_busy, cpu_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  // pipeline + bus slave side
  modport master (
    output cpu_req, cpu_wr, cpu_size, cpu_addr, cpu_wdata, cpu_stall, cpu_cancel,
    input  cpu_busy, cpu_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_sramlike_bridge.sv
// One sram-like bus transaction per M-stage memory instruction; stalls M until done and
// drains an already-accepted transaction when M is flushed.
module dmem_sramlike_bridge
  import cpu_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_sramlike_bridge_if.slave bus
);

  dbridge_state_t    state_q, state_d;
  logic              req_q,   req_d;
  logic              wr_q,    wr_d;
  logic [1:0]        size_q,  size_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req && !bus.cpu_cancel) begin
          req_d   = 1'b1;
          wr_d    = bus.cpu_wr;
          size_d  = bus.cpu_size;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (bus.data_addr_ok) begin
          req_d   = 1'b0;
          state_d = bus.cpu_cancel ? DRAIN : DATA;
        end else if (bus.cpu_cancel) begin
          // nothing reached the bus yet, so the request can simply be withdrawn
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bus.data_data_ok) begin
          if (bus.cpu_cancel) begin
            state_d = IDLE;
          end else begin
            rdata_d = bus.data_rdata;
            state_d = HOLD;
          end
        end else if (bus.cpu_cancel) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.data_data_ok) state_d = IDLE;
      end
      HOLD: begin
        // cpu_req is still the completed instruction's request here; never reissue it
        if (!bus.cpu_stall || bus.cpu_cancel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_busy   = ((state_q == IDLE) && bus.cpu_req && !bus.cpu_cancel) ||
                          (state_q == ADDR) || (state_q == DATA) || (state_q == DRAIN);
  assign bus.cpu_rdata  = rdata_q;
  assign bus.data_req   = req_q;
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_sramlike_bridge.sv
// Directed bench for the data-side sram-like bridge; inputs change and outputs are checked
// on the falling clock edge.
module tb_dmem_sramlike_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ntot  = 0;
  int   npass = 0;
  int   issues = 0;

  dmem_sramlike_bridge_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  dmem_sramlike_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  // a transaction is issued on every edge where the bus sees req together with addr_ok
  always @(posedge clk) if (!rst && bif.data_req && bif.data_addr_ok) issues++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got !== exp) $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else npass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cpu(input logic req, input logic wr, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    bif.cpu_req = req; bif.cpu_wr = wr; bif.cpu_size = sz;
    bif.cpu_addr = a;  bif.cpu_wdata = wd;
  endtask

  initial begin
    cpu(0, 0, 0, 0, 0);
    bif.cpu_stall = 0; bif.cpu_cancel = 0;
    bif.data_addr_ok = 0; bif.data_data_ok = 0; bif.data_rdata = 0;
    #1;
    check("rst_req",   bif.data_req, 0);
    check("rst_rdata", bif.cpu_rdata, 0);
    check("rst_addr",  bif.data_addr, 0);
    check("rst_busy",  bif.cpu_busy, 0);
    tick(); tick();
    rst = 0;

    // ---- load word, addr_ok after 2 cycles, data_ok 3 cycles later
    cpu(1, 0, 2, 32'h1000_0040, 0); #1;
    check("lw_busy0", bif.cpu_busy, 1);
    check("lw_req0",  bif.data_req, 0);
    tick(); #1;
    check("lw_req1",  bif.data_req, 1);
    check("lw_addr",  bif.data_addr, 32'h1000_0040);
    check("lw_wr",    bif.data_wr, 0);
    check("lw_size",  bif.data_size, 2);
    tick(); bif.data_addr_ok = 1; #1;
    check("lw_req2",  bif.data_req, 1);
    tick(); bif.data_addr_ok = 0; #1;
    check("lw_reqoff", bif.data_req, 0);
    check("lw_busy3",  bif.cpu_busy, 1);
    tick(); tick();
    bif.data_data_ok = 1; bif.data_rdata = 32'hDEAD_BEEF; #1;
    check("lw_busy5", bif.cpu_busy, 1);
    tick(); bif.data_data_ok = 0; bif.data_rdata = 0; #1;
    check("lw_hold_busy", bif.cpu_busy, 0);
    check("lw_rdata",     bif.cpu_rdata, 32'hDEAD_BEEF);
    cpu(0, 0, 0, 0, 0);
    tick(); #1;
    check("lw_idle_busy", bif.cpu_busy, 0);
    check("lw_issues",    issues, 1);

    // ---- store byte, immediate addr_ok, data_ok next cycle
    cpu(1, 1, 0, 32'h1000_0003, 32'h0000_00AB); #1;
    check("sb_busy1", bif.cpu_busy, 1);
    tick(); bif.data_addr_ok = 1; #1;
    check("sb_busy2", bif.cpu_busy, 1);
    check("sb_wr",    bif.data_wr, 1);
    check("sb_size",  bif.data_size, 0);
    check("sb_addr",  bif.data_addr, 32'h1000_0003);
    check("sb_wdata", bif.data_wdata, 32'h0000_00AB);
    tick(); bif.data_addr_ok = 0; bif.data_data_ok = 1; #1;
    check("sb_busy3", bif.cpu_busy, 1);
    check("sb_req3",  bif.data_req, 0);
    tick(); bif.data_data_ok = 0; #1;
    check("sb_busy4", bif.cpu_busy, 0);
    cpu(0, 0, 0, 0, 0);
    tick();

    // ---- load then HOLD under external stall with cpu_req still high
    cpu(1, 0, 2, 32'h0000_0020, 0);
    tick(); bif.data_addr_ok = 1;
    tick(); bif.data_addr_ok = 0; bif.data_data_ok = 1; bif.data_rdata = 32'hCAFE_F00D;
    tick(); bif.data_data_ok = 0; bif.data_rdata = 0; bif.cpu_stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("hold_busy",  bif.cpu_busy, 0);
      check("hold_req",   bif.data_req, 0);
      check("hold_rdata", bif.cpu_rdata, 32'hCAFE_F00D);
      tick();
    end
    bif.cpu_stall = 0; #1;
    check("hold_rel_busy", bif.cpu_busy, 0);
    check("hold_issues",   issues, 3);
    // next instruction is a new load; busy proves the bridge is back in IDLE
    tick(); cpu(1, 0, 2, 32'h0000_0024, 0); #1;
    check("hold_idle_busy", bif.cpu_busy, 1);

    // ---- cancel while waiting for addr_ok
    tick(); #1;
    check("cadr_req", bif.data_req, 1);
    bif.cpu_cancel = 1; #1;
    check("cadr_busy", bif.cpu_busy, 1);
    tick(); bif.cpu_cancel = 0; cpu(0, 0, 0, 0, 0); #1;
    check("cadr_reqoff", bif.data_req, 0);
    check("cadr_busy0",  bif.cpu_busy, 0);
    tick(); #1;
    check("cadr_issues", issues, 3);

    // ---- cancel in DATA, drain with data_ok 5 cycles later
    cpu(1, 0, 2, 32'h0000_0030, 0);
    tick(); bif.data_addr_ok = 1;
    tick(); bif.data_addr_ok = 0; bif.cpu_cancel = 1; cpu(0, 0, 0, 0, 0); #1;
    check("cdat_busy", bif.cpu_busy, 1);
    tick(); bif.cpu_cancel = 0; cpu(1, 0, 2, 32'h0000_0040, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_busy",  bif.cpu_busy, 1);
      check("drain_req",   bif.data_req, 0);
      check("drain_rdata", bif.cpu_rdata, 32'hCAFE_F00D);
      tick();
    end
    bif.data_data_ok = 1; bif.data_rdata = 32'h1234_5678;
    tick(); bif.data_data_ok = 0; bif.data_rdata = 0; #1;
    check("drain_done_req",   bif.data_req, 0);
    check("drain_done_busy",  bif.cpu_busy, 1);
    check("drain_done_rdata", bif.cpu_rdata, 32'hCAFE_F00D);
    tick(); #1;
    check("post_req",  bif.data_req, 1);
    check("post_addr", bif.data_addr, 32'h0000_0040);

    // ---- reset in DATA
    bif.data_addr_ok = 1;
    tick(); bif.data_addr_ok = 0; #1;
    check("rmid_busy", bif.cpu_busy, 1);
    rst = 1; cpu(0, 0, 0, 0, 0); #1;
    check("rmid_req",   bif.data_req, 0);
    check("rmid_rdata", bif.cpu_rdata, 0);
    check("rmid_busy0", bif.cpu_busy, 0);
    tick(); rst = 0;
    cpu(1, 0, 2, 32'h0000_0050, 0);
    tick(); bif.data_addr_ok = 1; #1;
    check("rpost_addr", bif.data_addr, 32'h0000_0050);
    tick(); bif.data_addr_ok = 0; bif.data_data_ok = 1; bif.data_rdata = 32'h0BAD_F00D;
    tick(); bif.data_data_ok = 0; bif.data_rdata = 0; #1;
    check("rpost_busy",  bif.cpu_busy, 0);
    check("rpost_rdata", bif.cpu_rdata, 32'h0BAD_F00D);
    cpu(0, 0, 0, 0, 0);
    tick(); #1;
    check("total_issues", issues, 6);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
